// File: rtl/score_digits_pkg.sv
// Shared types and constants for the score digit overlay feeder.
// Holds the glyph geometry, the BCD nibble type and the converter FSM encoding.
package score_digits_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 32;

    // Largest value representable in num_digits decimal digits (10^n - 1).
    function automatic int max_bcd_value(input int num_digits);
        int v;
        v = 1;
        for (int i = 0; i < num_digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep, last-wins request buffer.
// Latency: request accepted in IDLE -> digits/done update BIN_W+1 cycles later.
// No backpressure: requests arriving while busy overwrite the pending slot.
module bin2bcd_seq
    import score_digits_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_W-1:0]        score_dat,
    input  logic                    score_vld,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [31:0]      MAX_VAL32 = 32'(max_bcd_value(NUM_DIGITS));
    localparam logic [BIN_W-1:0] MAX_BIN   = MAX_VAL32[BIN_W-1:0];

    state_t               state;
    state_t               state_next;
    logic [SR_W-1:0]      sreg;
    logic [SR_W-1:0]      adj;
    logic [SR_W-1:0]      shifted;
    logic [CNT_W-1:0]     cnt;
    logic                 pend_vld;
    logic [BIN_W-1:0]     pend_dat;
    logic [BIN_W-1:0]     clamped;
    logic [BIN_W-1:0]     commit_src;
    logic [BCD_W-1:0]     digits_q;
    logic                 done_q;

    // Saturate at capture so every stored value fits in NUM_DIGITS digits.
    always_comb begin
        clamped = score_dat;
        if (32'(score_dat) > MAX_VAL32) begin
            clamped = MAX_BIN;
        end
    end

    always_comb begin
        adj = sreg;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (adj[BIN_W+4*d +: 4] >= 4'd5) begin
                adj[BIN_W+4*d +: 4] = adj[BIN_W+4*d +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;
    end

    // A request landing on the COMMIT edge supersedes anything already pending.
    always_comb begin
        commit_src = pend_dat;
        if (score_vld) begin
            commit_src = clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (score_vld) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (score_vld || pend_vld) begin
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (score_vld) begin
                        sreg <= {{BCD_W{1'b0}}, clamped};
                        cnt  <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    sreg <= shifted;
                    cnt  <= cnt - CNT_W'(1);
                    if (score_vld) begin
                        pend_vld <= 1'b1;
                        pend_dat <= clamped;
                    end
                end
                COMMIT: begin
                    digits_q <= sreg[SR_W-1 -: BCD_W];
                    done_q   <= 1'b1;
                    pend_vld <= 1'b0;
                    if (score_vld || pend_vld) begin
                        sreg <= {{BCD_W{1'b0}}, commit_src};
                        cnt  <= CNT_W'(BIN_W);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done   = done_q;
    assign digits = digits_q;

endmodule

// File: rtl/score_digits_ctrl.sv
// Score-to-digit feeder for the 16x32 glyph stage; optional LEADING_ZERO_BLANK_EN hides leading zero cells.
// Latency: pixel mapping 1 cycle; score conversion BIN_W+1 cycles.
// No backpressure: display path runs every cycle, score requests are last-wins while busy.
module score_digits_ctrl
    import score_digits_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter int          BIN_W      = 14,
    parameter logic [10:0] TOPLEFT_X  = 11'd16,
    parameter logic [10:0] TOPLEFT_Y  = 11'd8,
    parameter int          DIGIT_W    = GLYPH_W,
    parameter int          DIGIT_H    = GLYPH_H
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [BIN_W-1:0]        scoreIn,
    input  logic                    scoreValid,
    input  logic [10:0]             pixelX,
    input  logic [10:0]             pixelY,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digitsOut,
    output logic                    InsideRectangle,
    output logic [10:0]             offsetX,
    output logic [10:0]             offsetY,
    output logic [3:0]              digit
);

    localparam logic [10:0] X_END = TOPLEFT_X + 11'(NUM_DIGITS * DIGIT_W);
    localparam logic [10:0] Y_END = TOPLEFT_Y + 11'(DIGIT_H);

    logic [4*NUM_DIGITS-1:0] digits_w;
    logic                    in_x;
    logic                    in_y;
    logic                    in_xy;
    logic                    inside_next;
    logic [10:0]             dx;
    logic [10:0]             dy;
    logic [6:0]              idx;
    bcd_t                    cell_digit;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_bin2bcd (
        .clk       (clk),
        .rst       (resetN),
        .score_dat (scoreIn),
        .score_vld (scoreValid),
        .busy      (busy),
        .done      (done),
        .digits    (digits_w)
    );

    assign digitsOut = digits_w;

    // Range checks come first so the offsets below can never wrap.
    always_comb begin
        in_x  = (pixelX >= TOPLEFT_X) && (pixelX < X_END);
        in_y  = (pixelY >= TOPLEFT_Y) && (pixelY < Y_END);
        in_xy = in_x && in_y;
        dx    = '0;
        dy    = '0;
        if (in_x) begin
            dx = pixelX - TOPLEFT_X;
        end
        if (in_y) begin
            dy = pixelY - TOPLEFT_Y;
        end
        idx = dx[10:4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0] lead_zero;
    logic                blank;

    // lead_zero[d]: digit d and every more-significant digit are zero.
    always_comb begin
        lead_zero             = '0;
        lead_zero[NUM_DIGITS] = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            lead_zero[d] = lead_zero[d+1] && (digits_w[4*d +: 4] == 4'd0);
        end
    end

    always_comb begin
        cell_digit = '0;
        blank      = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (32'(idx) == 32'(NUM_DIGITS - 1 - d)) begin
                cell_digit = digits_w[4*d +: 4];
                blank      = lead_zero[d] && (d != 0);
            end
        end
        inside_next = in_xy && !blank;
    end
`else
    always_comb begin
        cell_digit = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (32'(idx) == 32'(NUM_DIGITS - 1 - d)) begin
                cell_digit = digits_w[4*d +: 4];
            end
        end
        inside_next = in_xy;
    end
`endif

    always_ff @(posedge clk) begin
        if (resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            digit           <= '0;
        end else begin
            InsideRectangle <= inside_next;
            if (in_xy) begin
                offsetX <= {7'b0, dx[3:0]};
                offsetY <= dy;
                digit   <= cell_digit;
            end else begin
                offsetX <= '0;
                offsetY <= '0;
                digit   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_score_digits_ctrl.sv
// Randomized self-checking bench for score_digits_ctrl against an arithmetic reference model.
module tb_score_digits_ctrl;

    localparam int TX = 16;
    localparam int TY = 8;

    logic        clk = 1'b0;
    logic        resetN;
    logic [13:0] scoreIn;
    logic        scoreValid;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        busy;
    logic        done;
    logic [15:0] digitsOut;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [3:0]  digit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_digits_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .scoreIn         (scoreIn),
        .scoreValid      (scoreValid),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .busy            (busy),
        .done            (done),
        .digitsOut       (digitsOut),
        .InsideRectangle (InsideRectangle),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .digit           (digit)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int s;
        s = sat(v);
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    task automatic load_score(input int v, output bit ok);
        scoreIn    = 14'(v);
        scoreValid = 1'b1;
        tick();
        scoreValid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            tick();
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetN     = 1'b1;
        scoreValid = 1'b0;
        scoreIn    = 14'd1234;
        pixelX     = 11'(TX + 5);
        pixelY     = 11'(TY + 5);
        repeat (3) tick();
        checks++;
        if ({busy, done, digitsOut} !== 18'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b digits=%h want 0/0/0000", busy, done, digitsOut);
        end
        checks++;
        if ({InsideRectangle, offsetX, offsetY, digit} !== 27'd0) begin
            errors++;
            $display("FAIL reset_disp: inside=%b ox=%0d oy=%0d digit=%0d want all 0",
                     InsideRectangle, offsetX, offsetY, digit);
        end
        resetN = 1'b0;
        tick();
    endtask

    task automatic test_convert();
        int vals[$];
        vals = '{1234, 16383, 0, 9999, 10000};
        repeat (4) vals.push_back(int'($urandom_range(16383)));
        foreach (vals[i]) begin
            int lat, busy_cnt;
            bit partial;
            logic [15:0] prev, got;
            prev = digitsOut;
            got = '0;
            lat = -1;
            busy_cnt = 0;
            partial = 1'b0;
            scoreIn    = 14'(vals[i]);
            scoreValid = 1'b1;
            tick();
            scoreValid = 1'b0;
            for (int k = 0; k < 25; k++) begin
                if (busy) busy_cnt++;
                if (done && lat < 0) begin
                    lat = k;
                    got = digitsOut;
                end
                if (lat < 0 && digitsOut !== prev) partial = 1'b1;
                tick();
            end
            checks++;
            if (lat != 15) begin
                errors++;
                $display("FAIL conv_latency v=%0d: done after %0d cycles want 15", vals[i], lat);
            end
            checks++;
            if (got !== to_bcd(vals[i])) begin
                errors++;
                $display("FAIL conv_value v=%0d: digits=%h want %h", vals[i], got, to_bcd(vals[i]));
            end
            checks++;
            if (busy_cnt != 15) begin
                errors++;
                $display("FAIL conv_busy v=%0d: busy %0d cycles want 15", vals[i], busy_cnt);
            end
            checks++;
            if (partial) begin
                errors++;
                $display("FAIL conv_partial v=%0d: digits changed before done (prev %h)", vals[i], prev);
            end
        end
    endtask

    // Requests at E0 (42), E0+3 (777), E0+5 (555): last one wins the pending slot.
    task automatic test_pending();
        int t_q[$];
        logic [15:0] v_q[$];
        scoreIn    = 14'd42;
        scoreValid = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            scoreValid = (k == 3) || (k == 5);
            scoreIn    = (k == 3) ? 14'd777 : 14'd555;
            tick();
            if (done) begin
                t_q.push_back(k);
                v_q.push_back(digitsOut);
            end
        end
        scoreValid = 1'b0;
        checks++;
        if (t_q.size() != 2) begin
            errors++;
            $display("FAIL pending_count: %0d done pulses want 2", t_q.size());
        end else begin
            checks++;
            if (t_q[0] != 15 || v_q[0] !== 16'h0042) begin
                errors++;
                $display("FAIL pending_first: t=%0d digits=%h want t=15 0042", t_q[0], v_q[0]);
            end
            checks++;
            if (t_q[1] != 30 || v_q[1] !== 16'h0555) begin
                errors++;
                $display("FAIL pending_last: t=%0d digits=%h want t=30 0555", t_q[1], v_q[1]);
            end
        end
    endtask

    // Request arriving on the COMMIT edge is taken by that same commit.
    task automatic test_commit_bypass();
        int a, b;
        int t_q[$];
        logic [15:0] v_q[$];
        a = int'($urandom_range(9999));
        b = int'($urandom_range(16383));
        scoreIn    = 14'(a);
        scoreValid = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            scoreValid = (k == 15);
            scoreIn    = 14'(b);
            tick();
            if (done) begin
                t_q.push_back(k);
                v_q.push_back(digitsOut);
            end
        end
        scoreValid = 1'b0;
        checks++;
        if (t_q.size() != 2) begin
            errors++;
            $display("FAIL bypass_count: %0d done pulses want 2", t_q.size());
        end else begin
            checks++;
            if (t_q[0] != 15 || v_q[0] !== to_bcd(a)) begin
                errors++;
                $display("FAIL bypass_first: t=%0d digits=%h want t=15 %h", t_q[0], v_q[0], to_bcd(a));
            end
            checks++;
            if (t_q[1] != 30 || v_q[1] !== to_bcd(b)) begin
                errors++;
                $display("FAIL bypass_second: t=%0d digits=%h want t=30 %h", t_q[1], v_q[1], to_bcd(b));
            end
        end
    endtask

    // Event-level model: a conversion started at edge s reports at s+15; while one is
    // in flight (edges up to and including its report edge) newer requests replace the pending one.
    task automatic test_back_to_back();
        int exp_t[$], obs_t[$];
        logic [15:0] exp_v[$], obs_v[$];
        bit active, pv;
        int fin, cur, pval;
        active = 1'b0;
        pv = 1'b0;
        fin = 0;
        cur = 0;
        pval = 0;
        for (int n = 1; n <= 340; n++) begin
            bit req;
            int val;
            req = (n <= 300) && ($urandom_range(5) == 0);
            val = int'($urandom_range(16383));
            scoreValid = req;
            scoreIn    = 14'(val);
            if (req) begin
                if (active && n <= fin) begin
                    pv = 1'b1;
                    pval = val;
                end else begin
                    active = 1'b1;
                    cur = val;
                    fin = n + 15;
                end
            end
            if (active && n == fin) begin
                exp_t.push_back(n);
                exp_v.push_back(to_bcd(cur));
                if (pv) begin
                    cur = pval;
                    pv = 1'b0;
                    fin = n + 15;
                end else begin
                    active = 1'b0;
                end
            end
            tick();
            if (done) begin
                obs_t.push_back(n);
                obs_v.push_back(digitsOut);
            end
        end
        scoreValid = 1'b0;
        checks++;
        if (obs_t.size() != exp_t.size()) begin
            errors++;
            $display("FAIL stream_count: %0d done pulses want %0d", obs_t.size(), exp_t.size());
        end else begin
            foreach (exp_t[i]) begin
                checks++;
                if (obs_t[i] != exp_t[i] || obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL stream_event %0d: t=%0d digits=%h want t=%0d %h",
                             i, obs_t[i], obs_v[i], exp_t[i], exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_display();
        int vals[$];
        vals = '{1234, 7, 0};
        vals.push_back(int'($urandom_range(16383)));
        vals.push_back(int'($urandom_range(99)));
        foreach (vals[i]) begin
            bit ok;
            int s;
            int px_q[$], py_q[$];
            load_score(vals[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL disp_load v=%0d: no done within bound", vals[i]);
            end
            s = sat(vals[i]);
            px_q = '{TX + 21, TX + 64, TX - 1, TX, TX + 63, TX + 5, TX + 17, TX + 33, TX + 49};
            py_q = '{TY + 7, TY + 7, TY, TY - 1, TY + 31, TY + 32, TY + 3, TY + 3, TY + 3};
            repeat (25) begin
                px_q.push_back(int'($urandom_range(100)));
                py_q.push_back(int'($urandom_range(50)));
            end
            foreach (px_q[j]) begin
                int px, py, dn, eox, eoy, ed;
                bit geo, vis;
                px = px_q[j];
                py = py_q[j];
                geo = (px >= TX) && (px < TX + 64) && (py >= TY) && (py < TY + 32);
                dn = 0;
                eox = 0;
                eoy = 0;
                ed = 0;
                if (geo) begin
                    dn  = 3 - (px - TX) / 16;
                    eox = (px - TX) % 16;
                    eoy = py - TY;
                    ed  = (s / pow10(dn)) % 10;
                end
                vis = geo;
`ifdef LEADING_ZERO_BLANK_EN
                if (geo && dn != 0 && s < pow10(dn)) vis = 1'b0;
`endif
                pixelX = 11'(px);
                pixelY = 11'(py);
                tick();
                checks++;
                if (InsideRectangle !== vis) begin
                    errors++;
                    $display("FAIL disp_inside v=%0d (%0d,%0d): got %b want %b", s, px, py, InsideRectangle, vis);
                end
                checks++;
                if (offsetX !== 11'(eox) || offsetY !== 11'(eoy)) begin
                    errors++;
                    $display("FAIL disp_offset v=%0d (%0d,%0d): got %0d/%0d want %0d/%0d",
                             s, px, py, offsetX, offsetY, eox, eoy);
                end
                checks++;
                if (digit !== 4'(ed)) begin
                    errors++;
                    $display("FAIL disp_digit v=%0d (%0d,%0d): got %0d want %0d", s, px, py, digit, ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        load_score(5555, ok);
        checks++;
        if (!ok || digitsOut !== 16'h5555) begin
            errors++;
            $display("FAIL midrst_pre: done=%b digits=%h want 1 5555", ok, digitsOut);
        end
        scoreIn    = 14'd9999;
        scoreValid = 1'b1;
        tick();
        scoreValid = 1'b0;
        repeat (5) tick();
        resetN = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || digitsOut !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: busy=%b digits=%h done=%b want 0 0000 0", busy, digitsOut, done);
        end
        resetN = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midrst_after: activity after reset, digits=%h want idle 0000", digitsOut);
        end
    endtask

    initial begin
        resetN     = 1'b1;
        scoreValid = 1'b0;
        scoreIn    = '0;
        pixelX     = '0;
        pixelY     = '0;
        test_reset();
        test_convert();
        test_pending();
        test_commit_bypass();
        test_back_to_back();
        test_display();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_digits_ctrl.md
Name: score_digits_ctrl

Overview:
Upstream feeder for the 16x32 digit bitmap stage in the game-stats overlay. Accepts a binary score and converts it to NUM_DIGITS BCD digits with a sequential double-dabble engine. Holds the converted digits stable for display. Per pixel, it produces the digit code, the in-rectangle flag and the 11-bit X/Y offsets that the bitmap stage consumes.

Parameters:
NUM_DIGITS, 4, digits displayed; the most significant digit is leftmost.
BIN_W, 14, width of the binary score input.
TOPLEFT_X, 11'd16, screen X of the digit field's left edge.
TOPLEFT_Y, 11'd8, screen Y of the digit field's top edge.
DIGIT_W, 16, glyph width in pixels; fixed at 16 (power of 2).
DIGIT_H, 32, glyph height in pixels.

Ports:
clk  in  1  system clock
resetN  in  1  synchronous reset, active-high (port name kept per codebase convention; polarity is high)
scoreIn  in  BIN_W  binary score
scoreValid  in  1  single-cycle request to convert scoreIn
pixelX  in  11  current pixel X
pixelY  in  11  current pixel Y
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when the displayed digits update
digitsOut  out  4*NUM_DIGITS  displayed BCD digits; digit 0 is in the LSBs
InsideRectangle  out  1  pixel lies in a displayed digit cell
offsetX  out  11  X offset inside the cell, 0..15
offsetY  out  11  Y offset inside the cell, 0..31
digit  out  4  BCD code for the current cell

Behaviour:
- Reset (resetN=1 at an edge) clears all outputs, FSM, pending buffer and shift register to 0; state goes to IDLE. Reset mid-conversion discards the conversion; digitsOut reads 0.
- Saturation: scoreIn is clamped to 10^NUM_DIGITS-1 at capture time (9999 by default).
- FSM states:
  - IDLE: on scoreValid, load {BCD=0, bin=clamped scoreIn}, set cnt=BIN_W, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift the whole register left by 1 and decrement cnt. When cnt reaches 1, go to COMMIT.
  - COMMIT: copy the BCD field to digitsOut and pulse done. If a value is pending, load it and go to SHIFT; otherwise go to IDLE.
- Latency: scoreValid sampled in IDLE at edge E0 → digitsOut and done change at edge E0+BIN_W+1 (15 cycles by default).
- busy is high in SHIFT and COMMIT.
- scoreValid while busy: the value is stored in a one-deep pending buffer; a newer request overwrites the older one (last wins).
- scoreValid in the same cycle as COMMIT: the new value goes to the pending buffer and is consumed by that same COMMIT.
- digitsOut never shows a partial conversion.
- Display path, registered with 1-cycle latency from pixelX/pixelY:
  - inside = TOPLEFT_X <= pixelX < TOPLEFT_X+NUM_DIGITS*16 and TOPLEFT_Y <= pixelY < TOPLEFT_Y+32.
  - idx = (pixelX-TOPLEFT_X)>>4; the cell shows digit number NUM_DIGITS-1-idx.
  - offsetX = {7'b0, (pixelX-TOPLEFT_X)[3:0]}; offsetY = pixelY-TOPLEFT_Y.
  - Outside the field: InsideRectangle=0, offsets=0, digit=0.
  - Subtractions use 11-bit unsigned arithmetic. Compare before subtracting so no wrap-around is possible.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: InsideRectangle is forced to 0 for cells whose digit and all more-significant digits are 0. The least significant digit is always shown, so a score of 0 displays a single "0".
- Undefined: all NUM_DIGITS cells are drawn, leading zeros included.

Decomposition:
- Package score_digits_pkg:
  - typedef bcd_t (logic[3:0]).
  - FSM state enum {IDLE, SHIFT, COMMIT}.
  - constants GLYPH_W=16, GLYPH_H=32.
  - function max_bcd_value(NUM_DIGITS).
- One sub-module, bin2bcd_seq, holds the FSM, pending buffer and shift register. The top level keeps the pixel-mapping pipeline.

Test Plan:
- Reset, then scoreValid with scoreIn=1234 → busy for 15 cycles; done pulse at E0+15; digitsOut=16'h1234.
- scoreIn=16383 → digitsOut=16'h9999 (saturation).
- scoreValid=0042 at E0, then 0777 at E0+3 and 0555 at E0+5 → done with 16'h0042 at E0+15; next done shows 16'h0555 at E0+30; 0777 is never shown.
- digitsOut=16'h1234; pixelX=TOPLEFT_X+21, pixelY=TOPLEFT_Y+7 → one cycle later: InsideRectangle=1, digit=2, offsetX=5, offsetY=7. pixelX=TOPLEFT_X+64 → InsideRectangle=0.
- Assert resetN at SHIFT cycle 6 of a 9999 conversion → next cycle: busy=0, digitsOut=0, no done pulse.
- With LEADING_ZERO_BLANK_EN, digitsOut=16'h0007 → cells 0–2 give InsideRectangle=0; cell 3 gives 1 with digit=7. With digitsOut=0, only cell 3 is drawn.
